// File: rtl/fetch_decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_unit_if
// Purpose  : Instruction-fetch req/ack memory bus between fetch unit and memory.
// Revision : 1.0
// ============================================================================
interface fetch_decode_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_unit
// Purpose  : PC, IR and branch-target front end of a multicycle MIPS datapath.
// Revision : 1.0
// ============================================================================
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    fetch_decode_unit_if.master mem,
    output logic [15:0]         imm_out,
    input  logic [31:0]         br_offset,
    input  logic                resolve_valid,
    input  logic                take_branch,
    input  logic                take_jump,
    output logic [31:0]         pc,
    output logic [31:0]         ir,
    output logic [31:0]         target,
    output logic                ir_valid,
    output logic                fetch_err
);

    localparam logic [31:0] c_reset_pc  = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [7:0]  c_wait_last = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DECODE  = 2'd2,
        ST_RESOLVE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ir;
    logic [31:0] w_ir_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_nxt;
    logic        w_mem_req;
    logic        w_ir_valid;
    logic        w_fetch_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= c_reset_pc;
            r_ir       <= 32'd0;
            r_target   <= 32'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_target   <= w_target_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_target_nxt = r_target;
        w_wait_nxt   = r_wait_cnt;
        w_mem_req    = 1'b0;
        w_ir_valid   = 1'b0;
        w_fetch_err  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                w_mem_req = 1'b1;
                // An ack wins over a timeout landing in the same cycle.
                if (mem.mem_ack) begin
                    w_ir_nxt    = mem.mem_rdata;
                    w_pc_nxt    = r_pc + 32'd4;
                    w_wait_nxt  = 8'd0;
                    w_state_nxt = ST_DECODE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_fetch_err = 1'b1;
                    w_wait_nxt  = 8'd0;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                end
            end

            ST_DECODE: begin
                // pc is already PC+4 here, matching MIPS branch semantics.
                w_target_nxt = r_pc + br_offset;
                w_state_nxt  = ST_RESOLVE;
            end

            ST_RESOLVE: begin
                w_ir_valid = 1'b1;
                if (resolve_valid) begin
                    if (take_jump) begin
                        w_pc_nxt = {r_pc[31:28], r_ir[25:0], 2'b00};
                    end else if (take_branch) begin
                        w_pc_nxt = r_target;
                    end
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_pc;
    assign imm_out      = r_ir[15:0];
    assign pc           = r_pc;
    assign ir           = r_ir;
    assign target       = r_target;
    assign ir_valid     = w_ir_valid;
    assign fetch_err    = w_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_unit
// Purpose  : Directed bench for fetch_decode_unit against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_fetch_decode_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0040;
    localparam int          TB_MAX_WAIT = 3;

    localparam int P_IDLE    = 0;
    localparam int P_FETCH   = 1;
    localparam int P_DECODE  = 2;
    localparam int P_RESOLVE = 3;

    logic        clk;
    logic        reset;
    logic [15:0] imm_out;
    logic [31:0] br_offset;
    logic        resolve_valid;
    logic        take_branch;
    logic        take_jump;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] target;
    logic        ir_valid;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_unit_if bus ();

    fetch_decode_unit #(
        .RESET_PC (TB_RESET_PC),
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (bus.master),
        .imm_out       (imm_out),
        .br_offset     (br_offset),
        .resolve_valid (resolve_valid),
        .take_branch   (take_branch),
        .take_jump     (take_jump),
        .pc            (pc),
        .ir            (ir),
        .target        (target),
        .ir_valid      (ir_valid),
        .fetch_err     (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: tracks the instruction phase and architectural
    // registers, compares every cycle, then advances on the inputs that the
    // coming rising edge will see.
    int          m_phase;
    int          m_miss;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_target;

    initial begin
        m_valid  = 1'b0;
        m_phase  = P_IDLE;
        m_miss   = 0;
        m_pc     = 32'd0;
        m_ir     = 32'd0;
        m_target = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (m_valid) begin
                chk("mem_req",   {31'd0, bus.mem_req}, {31'd0, (m_phase == P_FETCH)});
                chk("mem_addr",  bus.mem_addr, m_pc);
                chk("pc",        pc, m_pc);
                chk("ir",        ir, m_ir);
                chk("imm_out",   {16'd0, imm_out}, {16'd0, m_ir[15:0]});
                chk("target",    target, m_target);
                chk("ir_valid",  {31'd0, ir_valid}, {31'd0, (m_phase == P_RESOLVE)});
                chk("fetch_err", {31'd0, fetch_err},
                    {31'd0, (m_phase == P_FETCH && !bus.mem_ack &&
                             ((m_miss + 1) % TB_MAX_WAIT) == 0)});
            end
            if (reset) begin
                m_valid  = 1'b1;
                m_phase  = P_IDLE;
                m_pc     = TB_RESET_PC;
                m_ir     = 32'd0;
                m_target = 32'd0;
                m_miss   = 0;
            end else if (m_valid) begin
                case (m_phase)
                    P_IDLE: m_phase = P_FETCH;
                    P_FETCH: begin
                        if (bus.mem_ack) begin
                            m_ir    = bus.mem_rdata;
                            m_pc    = m_pc + 32'd4;
                            m_miss  = 0;
                            m_phase = P_DECODE;
                        end else begin
                            m_miss++;
                        end
                    end
                    P_DECODE: begin
                        m_target = m_pc + br_offset;
                        m_phase  = P_RESOLVE;
                    end
                    default: begin
                        if (resolve_valid) begin
                            if (take_jump)
                                m_pc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
                            else if (take_branch)
                                m_pc = m_target;
                            m_phase = P_FETCH;
                        end
                    end
                endcase
            end
        end
    end

    // Applies one cycle of inputs at the falling edge; returns before the
    // next rising edge so literal checks see the current cycle.
    task automatic cyc(input logic a_rst, input logic a_ack, input logic [31:0] a_rdata,
                       input logic [31:0] a_off, input logic a_rv, input logic a_tb,
                       input logic a_tj);
        @(negedge clk);
        reset         = a_rst;
        bus.mem_ack   = a_ack;
        bus.mem_rdata = a_rdata;
        br_offset     = a_off;
        resolve_valid = a_rv;
        take_branch   = a_tb;
        take_jump     = a_tj;
        #3;
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        br_offset     = 32'd0;
        resolve_valid = 1'b0;
        take_branch   = 1'b0;
        take_jump     = 1'b0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("lit reset pc", pc, 32'h0000_0040);
        chk("lit reset ir", ir, 32'd0);

        // First instruction, not-taken branch.
        cyc(0, 1, 32'h1000_0003, 0, 0, 0, 0);
        chk("lit fetch req", {31'd0, bus.mem_req}, 32'd1);
        chk("lit fetch addr", bus.mem_addr, 32'h0000_0040);
        cyc(0, 1, 32'hFFFF_FFFF, 32'h0000_000C, 0, 0, 0);
        chk("lit ir load", ir, 32'h1000_0003);
        chk("lit pc+4", pc, 32'h0000_0044);
        chk("lit imm", {16'd0, imm_out}, 32'h0000_0003);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("lit target", target, 32'h0000_0050);
        chk("lit ir_valid", {31'd0, ir_valid}, 32'd1);

        // Reset mid-fetch with a coincident ack, then a late ack in IDLE.
        cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("lit seq addr", bus.mem_addr, 32'h0000_0044);
        cyc(0, 1, 32'h1234_5678, 0, 0, 0, 0);
        chk("lit rst fetch pc", pc, 32'h0000_0040);
        chk("lit rst fetch ir", ir, 32'd0);
        cyc(0, 1, 32'h1000_0003, 0, 0, 0, 0);
        chk("lit late ack ir", ir, 32'd0);

        // Taken branch after stalled resolve.
        cyc(0, 0, 0, 32'h0000_000C, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);

        // Timeout pulses on every third unacked cycle; ack beats timeout.
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) cyc(0, 1, 32'h1000_FFFC, 0, 0, 0, 0);
            else        cyc(0, 0, 0, 0, 0, 0, 0);
            chk("lit to addr", bus.mem_addr, 32'h0000_0050);
            chk("lit to err", {31'd0, fetch_err}, {31'd0, (i == 3 || i == 6)});
        end

        // Branch to the top of memory, then fetch wraps pc to zero.
        cyc(0, 0, 0, 32'hFFFF_FFA8, 0, 0, 0);
        chk("lit imm neg", {16'd0, imm_out}, 32'h0000_FFFC);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("lit target top", target, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h2000_0000, 0, 0, 0, 0);
        cyc(0, 0, 0, 32'h8000_000C, 0, 0, 0);
        chk("lit wrap pc", pc, 32'h0000_0000);
        cyc(0, 0, 0, 0, 1, 1, 0);

        // Jump wins over branch; negative offset into target.
        cyc(0, 1, 32'h0800_0100, 0, 0, 0, 0);
        cyc(0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0);
        chk("lit jump pc", pc, 32'h8000_0010);
        cyc(0, 1, 32'h5555_5555, 0, 1, 1, 1);
        chk("lit neg target", target, 32'h8000_0000);
        cyc(0, 1, 32'h1111_1111, 0, 0, 0, 0);
        chk("lit jump addr", bus.mem_addr, 32'h8000_0400);

        // Reset while waiting in resolve.
        cyc(0, 0, 0, 32'h0000_0004, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit rst resolve pc", pc, 32'h0000_0040);
        chk("lit rst resolve target", target, 32'd0);
        chk("lit rst resolve valid", {31'd0, ir_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
